keypad_emulator: RTL and testbench



---
 rtl/keypad_emulator.sv | 157 +++++++++++++++
 tb/tb_keypad_emulator.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// 4x4 matrix-keypad emulator: closes one row/column contact per accepted command.
// Optional contact bounce around press/release is compiled in with KEYEMU_BOUNCE_EN.
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES    = 100,
  parameter int unsigned GAP_CYCLES     = 50,
  parameter int unsigned BOUNCE_CYCLES  = 4,
  parameter int unsigned BOUNCE_TOGGLES = 2
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_key,
  output logic       cmd_ready,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       busy,
  output logic       pressed,
  output logic       done
);

  localparam int unsigned CNT_W     = 24;
  localparam int unsigned CNT_LIMIT = 32'd1 << CNT_W;

  // Reject parameter sets the 24-bit phase counter cannot express.
  if (HOLD_CYCLES == 0 || GAP_CYCLES == 0 || BOUNCE_CYCLES == 0 ||
      HOLD_CYCLES >= CNT_LIMIT || GAP_CYCLES >= CNT_LIMIT ||
      2 * BOUNCE_TOGGLES * BOUNCE_CYCLES >= CNT_LIMIT) begin : g_bad_params
    $error("keypad_emulator: illegal parameter value");
  end

`ifdef KEYEMU_BOUNCE_EN
  localparam int unsigned BOUNCE_LEN = 2 * BOUNCE_TOGGLES * BOUNCE_CYCLES;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    GAP   = 3'd2
`ifdef KEYEMU_BOUNCE_EN
    ,
    PRESS_B = 3'd3,
    REL_B   = 3'd4
`endif
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       key, key_n;
  logic             contact, contact_n;
  logic             done_n;
`ifdef KEYEMU_BOUNCE_EN
  logic [CNT_W-1:0] seg, seg_n;
`endif

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      cnt       <= '0;
      key       <= '0;
      contact   <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
`ifdef KEYEMU_BOUNCE_EN
      seg       <= '0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      key       <= key_n;
      contact   <= contact_n;
      done      <= done_n;
      busy      <= (state_n != IDLE);
      cmd_ready <= (state_n == IDLE);
`ifdef KEYEMU_BOUNCE_EN
      seg       <= seg_n;
`endif
    end
  end

  // Next-state, phase counting and contact sequencing.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    key_n     = key;
    contact_n = contact;
    done_n    = 1'b0;
`ifdef KEYEMU_BOUNCE_EN
    seg_n     = seg + CNT_W'(1);
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (cmd_valid) begin
          key_n     = cmd_key;
          contact_n = 1'b1;
`ifdef KEYEMU_BOUNCE_EN
          seg_n     = '0;
          if (BOUNCE_LEN != 0) state_n = PRESS_B;
          else                 state_n = HOLD;
`else
          state_n   = HOLD;
`endif
        end
      end
`ifdef KEYEMU_BOUNCE_EN
      // Bounce: flip the contact at the end of every segment.
      PRESS_B, REL_B: begin
        if (seg == CNT_W'(BOUNCE_CYCLES - 1)) begin
          seg_n     = '0;
          contact_n = ~contact;
        end
        if (cnt == CNT_W'(BOUNCE_LEN - 1)) begin
          cnt_n     = '0;
          contact_n = (state == PRESS_B);
          state_n   = (state == PRESS_B) ? HOLD : GAP;
        end
      end
`endif
      HOLD: begin
        if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          cnt_n     = '0;
          contact_n = 1'b0;
`ifdef KEYEMU_BOUNCE_EN
          seg_n     = '0;
          if (BOUNCE_LEN != 0) state_n = REL_B;
          else                 state_n = GAP;
`else
          state_n   = GAP;
`endif
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: begin
        cnt_n     = '0;
        contact_n = 1'b0;
        state_n   = IDLE;
      end
    endcase
  end

  assign pressed = contact;

  // Zero-latency switch path from row drive to column return.
  always_comb begin
    col = 4'hF;
    if (contact && !row[key[3:2]]) col[key[1:0]] = 1'b0;
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator at default parameters; follows KEYEMU_BOUNCE_EN.
module tb_keypad_emulator;

  localparam int H  = 100;
  localparam int G  = 50;
  localparam int BC = 4;
`ifdef KEYEMU_BOUNCE_EN
  localparam int P  = 16;
`else
  localparam int P  = 0;
`endif
  localparam int LAST = 2 * P + H + G + 1;

  logic       clk = 1'b0;
  logic       RSTn;
  logic       cmd_valid;
  logic [3:0] cmd_key;
  logic       cmd_ready;
  logic [3:0] row;
  logic [3:0] col;
  logic       busy;
  logic       pressed;
  logic       done;

  int n_chk = 0;
  int n_bad = 0;

  keypad_emulator dut (
    .clk       (clk),
    .RSTn      (RSTn),
    .cmd_valid (cmd_valid),
    .cmd_key   (cmd_key),
    .cmd_ready (cmd_ready),
    .row       (row),
    .col       (col),
    .busy      (busy),
    .pressed   (pressed),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Contact state in cycle i after the accepting edge (i = 1 is the first).
  function automatic bit closed_at(input int i);
    if (i <= P)         return ((i - 1) / BC) % 2 == 0;
    if (i <= P + H)     return 1'b1;
    if (i <= 2 * P + H) return ((i - P - H - 1) / BC) % 2 == 1;
    return 1'b0;
  endfunction

  // One command; col_a/col_h are the closed-contact column values for row_a/row_h.
  task automatic run_seq(input string tag, input logic [3:0] key,
                         input logic [3:0] row_a, input logic [3:0] col_a,
                         input logic [3:0] row_h, input logic [3:0] col_h,
                         input bit busy_cmd, input int abort_at);
    int  dones;
    bit  cl;
    bit  in_hold;
    logic [3:0] exp_col;
    dones     = 0;
    row       = row_a;
    cmd_key   = key;
    cmd_valid = 1'b1;
    #1;
    check({tag, "/ready0"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_key   = 4'h0;
    for (int i = 1; i <= LAST; i++) begin
      in_hold = (i > P) && (i <= P + H);
      row     = in_hold ? row_h : row_a;
      if (busy_cmd && i >= P + 10 && i < P + 20) begin
        cmd_valid = 1'b1;
        cmd_key   = 4'h3;
      end else begin
        cmd_valid = 1'b0;
      end
      #1;
      cl      = closed_at(i);
      exp_col = cl ? (in_hold ? col_h : col_a) : 4'hF;
      check($sformatf("%s/col@%0d", tag, i), 32'(col), 32'(exp_col));
      check($sformatf("%s/pressed@%0d", tag, i), 32'(pressed), 32'(cl));
      check($sformatf("%s/busy@%0d", tag, i), 32'(busy), 32'(i < LAST));
      check($sformatf("%s/ready@%0d", tag, i), 32'(cmd_ready), 32'(i == LAST));
      check($sformatf("%s/done@%0d", tag, i), 32'(done), 32'(i == LAST));
      if (done) dones++;
      if (i == abort_at) begin
        RSTn = 1'b0;
        #1;
        check({tag, "/abort_col"}, 32'(col), 32'hF);
        check({tag, "/abort_pressed"}, 32'(pressed), 32'd0);
        check({tag, "/abort_busy"}, 32'(busy), 32'd0);
        check({tag, "/abort_done"}, 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        RSTn = 1'b1;
        return;
      end
      if (i < LAST) @(negedge clk);
    end
    check({tag, "/done_count"}, 32'(dones), 32'd1);
  endtask

  initial begin
    RSTn      = 1'b1;
    cmd_valid = 1'b0;
    cmd_key   = 4'h0;
    row       = 4'h0;
    #2 RSTn   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst/col_row0", 32'(col), 32'hF);
    row = 4'b1101;
    #1;
    check("rst/col_row1101", 32'(col), 32'hF);
    check("rst/ready", 32'(cmd_ready), 32'd1);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/pressed", 32'(pressed), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    @(negedge clk);
    RSTn = 1'b1;
    @(negedge clk);

    run_seq("k6",        4'd6,  4'b1101, 4'b1011, 4'b1101, 4'b1011, 1'b0, 0);
    run_seq("wrong_row", 4'd6,  4'b1101, 4'b1011, 4'b1110, 4'hF,    1'b0, 0);
    run_seq("busy_cmd",  4'd6,  4'b1101, 4'b1011, 4'b1101, 4'b1011, 1'b1, 0);
    run_seq("k15",       4'd15, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 1'b0, 0);
    run_seq("k9_allrow", 4'd9,  4'b0000, 4'b1101, 4'b0000, 4'b1101, 1'b0, 0);
    @(negedge clk);
    run_seq("abort",     4'd6,  4'b1101, 4'b1011, 4'b1101, 4'b1011, 1'b0, 50);

    row = 4'b1101;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("post_abort/done@%0d", i), 32'(done), 32'd0);
      check($sformatf("post_abort/col@%0d", i), 32'(col), 32'hF);
      check($sformatf("post_abort/ready@%0d", i), 32'(cmd_ready), 32'd1);
      @(negedge clk);
    end
    run_seq("k3",        4'd3,  4'b1110, 4'b0111, 4'b1110, 4'b0111, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
